// File: rtl/arb_rr_2to1.sv
`default_nettype none
// ============================================================================
// arb_rr_2to1 : two-requester round-robin arbiter with a one-beat output
//               register, per-input beat counters and a mux-select output.
// Revision    : 1.0
// ============================================================================
module arb_rr_2to1 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic [7:0]       cnt0,
   output logic [7:0]       cnt1
);

   // Reset leaves input 1 as last grant so the first contested pick goes to 0.
   localparam logic c_LAST_GRANT_RST = 1'b1;

   logic             last_grant_q, last_grant_d;
   logic             out_valid_q,  out_valid_d;
   logic [WIDTH-1:0] out_data_q,   out_data_d;
   logic             out_src_q,    out_src_d;
   logic [7:0]       cnt0_q,       cnt0_d;
   logic [7:0]       cnt1_q,       cnt1_d;

   logic             w_pick;
   logic             w_slot_free;
   logic             w_xfer0;
   logic             w_xfer1;

   always_comb begin
      if (in0_valid && in1_valid) begin
         w_pick = ~last_grant_q;
      end else begin
         w_pick = in1_valid & ~in0_valid;
      end
   end

   // A held beat consumed this cycle frees the slot for a same-cycle refill.
   assign w_slot_free = ~out_valid_q | out_ready;

   assign w_xfer0 = ~rst & w_slot_free & ~w_pick & in0_valid;
   assign w_xfer1 = ~rst & w_slot_free &  w_pick & in1_valid;

   always_comb begin
      last_grant_d = last_grant_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      if (w_xfer0) begin
         out_valid_d  = 1'b1;
         out_data_d   = in0_data;
         out_src_d    = 1'b0;
         last_grant_d = 1'b0;
         cnt0_d       = cnt0_q + 8'd1;
      end else if (w_xfer1) begin
         out_valid_d  = 1'b1;
         out_data_d   = in1_data;
         out_src_d    = 1'b1;
         last_grant_d = 1'b1;
         cnt1_d       = cnt1_q + 8'd1;
      end else if (w_slot_free) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= c_LAST_GRANT_RST;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= 1'b0;
         cnt0_q       <= 8'd0;
         cnt1_q       <= 8'd0;
      end else begin
         last_grant_q <= last_grant_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   assign sel       = w_pick;
   assign in0_ready = w_xfer0;
   assign in1_ready = w_xfer1;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign cnt0      = cnt0_q;
   assign cnt1      = cnt1_q;

endmodule
`default_nettype wire

// File: doc/arb_rr_2to1.md
ARB_RR_2TO1 -- requirements
Module: arb_rr_2to1

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each input and of the output beat.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in0_valid  input  1  requester 0 holds a beat.
REQ-006 in0_data  input  WIDTH  requester 0 payload.
REQ-007 in0_ready  output  1  requester 0 beat accepted this cycle when high with in0_valid.
REQ-008 in1_valid  input  1  requester 1 holds a beat.
REQ-009 in1_data  input  WIDTH  requester 1 payload.
REQ-010 in1_ready  output  1  requester 1 beat accepted this cycle when high with in1_valid.
REQ-011 sel  output  1  combinational select for the downstream 2:1 mux; index of the input picked this cycle.
REQ-012 out_valid  output  1  registered output beat present.
REQ-013 out_data  output  WIDTH  registered output payload.
REQ-014 out_src  output  1  index of the input that supplied out_data.
REQ-015 out_ready  input  1  consumer accepts the output beat.
REQ-016 cnt0, cnt1  output  8 each  beats accepted from input 0 / input 1, modulo 256.

Function
REQ-017 Slot free = !out_valid | out_ready (a held beat consumed this cycle frees the slot in the same cycle).
REQ-018 Pick: only in0_valid -> 0; only in1_valid -> 1; both -> !last_grant; neither -> 0.
REQ-019 sel SHALL equal pick every cycle, independent of slot state.
REQ-020 inN_ready SHALL be high iff slot free and pick == N and inN_valid; at most one ready high per cycle.
REQ-021 On transfer (inN_valid & inN_ready): next cycle out_valid=1, out_data=inN_data, out_src=N, last_grant=N, cntN increments by 1.
REQ-022 Slot free with no transfer: out_valid SHALL go 0 next cycle; out_data/out_src SHALL hold their last values.
REQ-023 out_valid & !out_ready: out_valid, out_data, out_src SHALL hold unchanged; both readies low.
REQ-024 Latency: input transfer to out_valid exactly 1 cycle; sustained throughput 1 beat per cycle when out_ready stays high.
REQ-025 Fairness: with both inputs continuously valid and out_ready high, grants SHALL strictly alternate 0,1,0,1...
REQ-026 last_grant SHALL change only on a transfer; stall cycles SHALL not rotate priority.
REQ-027 cnt0/cnt1 SHALL wrap 255 -> 0 without flag or saturation.
REQ-028 Inputs valid without being picked SHALL not be consumed; an input dropping valid before grant is not an error.

Reset
REQ-029 rst high at a clock edge: out_valid=0, out_data=0, out_src=0, last_grant=1, cnt0=cnt1=0.
REQ-030 During any cycle with rst high, in0_ready and in1_ready SHALL be 0; no transfer or counter update SHALL occur.
REQ-031 Reset while a beat is held (out_valid=1, out_ready=0) SHALL discard that beat.
REQ-032 First arbitration after reset with both inputs valid SHALL grant input 0.

Verification
REQ-033 Reset, then in0_valid=1 in0_data=0x11, in1_valid=0, out_ready=1 -> sel=0, in0_ready=1; next cycle out_valid=1, out_data=0x11, out_src=0, cnt0=1.
REQ-034 Both valid (in0_data=0xA0, in1_data=0xB0), out_ready=1 for 4 cycles -> out_src sequence 0,1,0,1; cnt0=2, cnt1=2.
REQ-035 Beat 0x5C held, out_ready=0 for 3 cycles with both inputs valid -> out_data stays 0x5C, both readies 0, last_grant unchanged; on release next grant goes to the other input.
REQ-036 rst asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=0, counters 0; with both inputs then valid, first grant is input 0.
REQ-037 256 consecutive input-1-only transfers from reset -> cnt1 wraps to 0, cnt0 stays 0, no beat lost (all 256 seen on output in order).
REQ-038 Idle (no valid, out_ready=1) after a beat -> out_valid drops to 0 one cycle later, out_data holds last value.
